// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller: turns hazard, branch and memory-busy requests into
// PC and pipeline-register enables/flushes, and keeps saturating event counters.
module pipeline_stall_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Stall,
    input  logic             BranchTaken,
    input  logic             MemBusy,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             EXMEMFlush,
    output logic             Stalled,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] WaitCnt
);

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    localparam int IDX_STALL = 0;
    localparam int IDX_FLUSH = 1;
    localparam int IDX_WAIT  = 2;

    state_t           state_q, state_d;
    logic [2:0]       inc_d;
    logic [CNT_W-1:0] cnt_q [3];

    always_comb begin
        state_d    = state_q;
        inc_d      = 3'b000;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        if (!reset) begin
            state_d    = RUN;
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXFlush  = 1'b1;
            EXMEMFlush = 1'b1;
        end else if (MemBusy) begin
            PCWrite          = 1'b0;
            IFIDWrite        = 1'b0;
            inc_d[IDX_WAIT]  = 1'b1;
        end else if (BranchTaken) begin
            // Any concurrent Stall belongs to a wrong-path instruction and is dropped.
            IFIDFlush        = 1'b1;
            IDEXFlush        = 1'b1;
            EXMEMFlush       = 1'b1;
            state_d          = RUN;
            inc_d[IDX_FLUSH] = 1'b1;
        end else if (Stall && state_q == RUN) begin
            PCWrite          = 1'b0;
            IFIDWrite        = 1'b0;
            IDEXFlush        = 1'b1;
            state_d          = BUBBLE;
            inc_d[IDX_STALL] = 1'b1;
        end else begin
            state_d = RUN;
        end
    end

    assign Stalled = ~PCWrite;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (!reset) begin
                    cnt_q[gi] <= '0;
                end else if (inc_d[gi] && (cnt_q[gi] != {CNT_W{1'b1}})) begin
                    cnt_q[gi] <= cnt_q[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign StallCnt = cnt_q[IDX_STALL];
    assign FlushCnt = cnt_q[IDX_FLUSH];
    assign WaitCnt  = cnt_q[IDX_WAIT];

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed scenarios plus random traffic against a
// rule-level model; a 16-bit and a 4-bit counter instance share the same stimulus.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic reset, Stall, BranchTaken, MemBusy;

    logic        pcw_a, ifw_a, iff_a, idf_a, exf_a, stl_a;
    logic [15:0] sc_a, fc_a, wc_a;
    logic        pcw_b, ifw_b, iff_b, idf_b, exf_b, stl_b;
    logic [3:0]  sc_b, fc_b, wc_b;

    int checks = 0;
    int errors = 0;

    // Model state: was a load-use bubble just inserted, and raw event totals.
    bit m_bubble;
    int m_stall, m_flush, m_wait;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .BranchTaken(BranchTaken), .MemBusy(MemBusy),
        .PCWrite(pcw_a), .IFIDWrite(ifw_a), .IFIDFlush(iff_a), .IDEXFlush(idf_a),
        .EXMEMFlush(exf_a), .Stalled(stl_a), .StallCnt(sc_a), .FlushCnt(fc_a), .WaitCnt(wc_a)
    );

    pipeline_stall_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .Stall(Stall), .BranchTaken(BranchTaken), .MemBusy(MemBusy),
        .PCWrite(pcw_b), .IFIDWrite(ifw_b), .IFIDFlush(iff_b), .IDEXFlush(idf_b),
        .EXMEMFlush(exf_b), .Stalled(stl_b), .StallCnt(sc_b), .FlushCnt(fc_b), .WaitCnt(wc_b)
    );

    // Expected {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, Stalled}.
    function automatic logic [5:0] exp_ctrl();
        if (!reset)                     return 6'b001111;
        if (MemBusy)                    return 6'b000001;
        if (BranchTaken)                return 6'b111110;
        if (Stall && !m_bubble)         return 6'b000101;
        return 6'b110000;
    endfunction

    function automatic int sat(input int v, input int w);
        int lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    function automatic logic [5:0] obs_a();
        return {pcw_a, ifw_a, iff_a, idf_a, exf_a, stl_a};
    endfunction

    function automatic logic [5:0] obs_b();
        return {pcw_b, ifw_b, iff_b, idf_b, exf_b, stl_b};
    endfunction

    task automatic drive(input logic r, input logic s, input logic b, input logic m);
        @(negedge clk);
        reset = r; Stall = s; BranchTaken = b; MemBusy = m;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            m_bubble = 0; m_stall = 0; m_flush = 0; m_wait = 0;
        end else if (MemBusy) begin
            m_wait++;
        end else if (BranchTaken) begin
            m_flush++; m_bubble = 0;
        end else if (Stall && !m_bubble) begin
            m_stall++; m_bubble = 1;
        end else begin
            m_bubble = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            checks++;
            if (obs_a() !== 6'b001111 || obs_b() !== 6'b001111) begin
                errors++;
                $display("FAIL reset_ctrl cyc %0d got %b/%b want 001111", i, obs_a(), obs_b());
            end
            tick();
        end
        drive(1, 0, 0, 0);
        checks++;
        if (sc_a !== 0 || fc_a !== 0 || wc_a !== 0 || sc_b !== 0 || fc_b !== 0 || wc_b !== 0) begin
            errors++;
            $display("FAIL reset_cnt got %0d %0d %0d want 0 0 0", sc_a, fc_a, wc_a);
        end
        checks++;
        if (obs_a() !== 6'b110000) begin
            errors++;
            $display("FAIL reset_release got %b want 110000", obs_a());
        end
        tick();
    endtask

    task automatic test_load_use();
        drive(1, 1, 0, 0);
        checks++;
        if (obs_a() !== 6'b000101) begin
            errors++;
            $display("FAIL load_use_c1 got %b want 000101", obs_a());
        end
        tick();
        checks++;
        if (sc_a !== 16'd1) begin
            errors++;
            $display("FAIL load_use_cnt1 got %0d want 1", sc_a);
        end
        drive(1, 1, 0, 0);
        checks++;
        if (obs_a() !== 6'b110000) begin
            errors++;
            $display("FAIL load_use_bubble got %b want 110000", obs_a());
        end
        tick();
        checks++;
        if (sc_a !== 16'd1) begin
            errors++;
            $display("FAIL load_use_cnt2 got %0d want 1", sc_a);
        end
    endtask

    task automatic test_stall_branch();
        drive(0, 0, 0, 0); tick();
        drive(1, 1, 1, 0);
        checks++;
        if (obs_a() !== 6'b111110) begin
            errors++;
            $display("FAIL stall_branch_ctrl got %b want 111110", obs_a());
        end
        tick();
        checks++;
        if (fc_a !== 16'd1 || sc_a !== 16'd0) begin
            errors++;
            $display("FAIL stall_branch_cnt got flush %0d stall %0d want 1 0", fc_a, sc_a);
        end
        drive(1, 1, 0, 0);
        checks++;
        if (obs_a() !== 6'b000101) begin
            errors++;
            $display("FAIL stall_branch_run got %b want 000101", obs_a());
        end
        tick();
    endtask

    task automatic test_freeze();
        drive(0, 0, 0, 0); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 1);
            checks++;
            if (obs_a() !== 6'b000001) begin
                errors++;
                $display("FAIL freeze_ctrl cyc %0d got %b want 000001", i, obs_a());
            end
            tick();
        end
        checks++;
        if (wc_a !== 16'd4 || sc_a !== 16'd0) begin
            errors++;
            $display("FAIL freeze_cnt got wait %0d stall %0d want 4 0", wc_a, sc_a);
        end
        drive(1, 1, 0, 0);
        checks++;
        if (obs_a() !== 6'b000101) begin
            errors++;
            $display("FAIL freeze_release got %b want 000101", obs_a());
        end
        tick();
        checks++;
        if (sc_a !== 16'd1) begin
            errors++;
            $display("FAIL freeze_stallcnt got %0d want 1", sc_a);
        end
    endtask

    task automatic test_reset_in_bubble();
        drive(1, 1, 0, 0); tick();
        drive(0, 1, 0, 0); tick();
        drive(1, 1, 0, 0);
        checks++;
        if (obs_a() !== 6'b000101 || sc_a !== 16'd0) begin
            errors++;
            $display("FAIL reset_bubble got %b cnt %0d want 000101 cnt 0", obs_a(), sc_a);
        end
        tick();
    endtask

    task automatic test_saturation();
        drive(0, 0, 0, 0); tick();
        for (int i = 1; i <= 20; i++) begin
            drive(1, $urandom_range(0, 1), 1, 0);
            tick();
            checks++;
            if (int'(fc_b) !== ((i > 15) ? 15 : i) || int'(fc_a) !== i) begin
                errors++;
                $display("FAIL saturation n %0d got %0d/%0d want %0d/%0d",
                         i, fc_b, fc_a, (i > 15) ? 15 : i, i);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 19) != 0), $urandom_range(0, 1),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
            checks++;
            if (obs_a() !== exp_ctrl() || obs_b() !== exp_ctrl()) begin
                errors++;
                $display("FAIL random_ctrl cyc %0d got %b/%b want %b", i, obs_a(), obs_b(), exp_ctrl());
            end
            tick();
            checks++;
            if (int'(sc_a) !== sat(m_stall, 16) || int'(fc_a) !== sat(m_flush, 16) ||
                int'(wc_a) !== sat(m_wait, 16) || int'(sc_b) !== sat(m_stall, 4) ||
                int'(fc_b) !== sat(m_flush, 4) || int'(wc_b) !== sat(m_wait, 4)) begin
                errors++;
                $display("FAIL random_cnt cyc %0d got %0d %0d %0d / %0d %0d %0d want %0d %0d %0d",
                         i, sc_a, fc_a, wc_a, sc_b, fc_b, wc_b, m_stall, m_flush, m_wait);
            end
        end
    endtask

    initial begin
        reset = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; MemBusy = 1'b0;
        m_bubble = 0; m_stall = 0; m_flush = 0; m_wait = 0;
        test_reset();
        test_load_use();
        test_stall_branch();
        test_freeze();
        test_reset_in_bubble();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Consumes the load-use `Stall` request from the hazard detection unit, the taken-branch flush request, and the data-memory busy signal. From these it drives the write enables and flush controls of the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. It guarantees exactly one bubble per load-use hazard and gives branch flushes priority over stalls. It also keeps saturating performance counters. It sits between the hazard unit and the pipeline registers in the 5-stage ARMv8 core.

Parameters:
- CNT_W, 16, width of each saturating performance counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- Stall  input  1  load-use hazard request from the hazard detection unit.
- BranchTaken  input  1  taken branch resolved in MEM; wrong-path instructions must be squashed.
- MemBusy  input  1  data memory not ready; the whole pipeline must freeze.
- PCWrite  output  1  PC register write enable.
- IFIDWrite  output  1  IF/ID register write enable.
- IFIDFlush  output  1  clear IF/ID to NOP.
- IDEXFlush  output  1  clear ID/EX control bits (bubble).
- EXMEMFlush  output  1  clear EX/MEM control bits.
- Stalled  output  1  high in any cycle where PCWrite=0.
- StallCnt  output  CNT_W  load-use bubbles inserted.
- FlushCnt  output  CNT_W  branch flush events.
- WaitCnt  output  CNT_W  MemBusy freeze cycles.

Behaviour:
- Control outputs are combinational (Mealy) from the state register and the current inputs, so they are valid in the same cycle as the requests. The state register and counters are registered.
- States:
  - RUN: normal operation.
  - BUBBLE: the cycle after a load-use bubble was inserted.
- Reset (reset=0 at a rising edge):
  - State becomes RUN; StallCnt, FlushCnt and WaitCnt become 0.
  - While reset=0: PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1, EXMEMFlush=1, Stalled=1. This clears the pipeline.
  - Reset asserted mid-stall or mid-freeze overrides everything; the first cycle after release is RUN.
- Priority when reset=1: MemBusy > BranchTaken > Stall (Stall is honoured only in RUN).
- Freeze (MemBusy=1, any state):
  - PCWrite=0, IFIDWrite=0, all flushes 0, Stalled=1.
  - State holds; BranchTaken and Stall are ignored this cycle. Upstream units keep those requests asserted until the freeze ends.
  - WaitCnt increments.
- Flush (MemBusy=0, BranchTaken=1, any state):
  - PCWrite=1 (target load), IFIDWrite=1, IFIDFlush=1, IDEXFlush=1, EXMEMFlush=1, Stalled=0.
  - Next state is RUN; a simultaneous Stall is discarded because it refers to a wrong-path instruction.
  - FlushCnt increments.
- Load-use stall (RUN, MemBusy=0, BranchTaken=0, Stall=1):
  - PCWrite=0, IFIDWrite=0, IDEXFlush=1, other flushes 0, Stalled=1.
  - Next state is BUBBLE; StallCnt increments.
- BUBBLE (MemBusy=0, BranchTaken=0):
  - Stall is masked, which gives at most one bubble per load and guarantees forward progress.
  - Outputs are normal (PCWrite=1, IFIDWrite=1, flushes 0). Next state is RUN.
- Normal (RUN, no requests): PCWrite=1, IFIDWrite=1, flushes 0, Stalled=0; state stays RUN.
- Counters:
  - Unsigned, increment by 1, saturate at 2^CNT_W-1 (no wrap).
  - Several counters may increment in different cycles; at most one counter increments per cycle.

Test Plan:
- Reset held low 3 cycles, then released → during reset PCWrite=0 and all three flushes=1; after release state is RUN, all counters 0, PCWrite=1.
- Stall=1 for 2 consecutive cycles in RUN → cycle 1: PCWrite=0, IFIDWrite=0, IDEXFlush=1, StallCnt=1; cycle 2 (BUBBLE): Stall masked, PCWrite=1, StallCnt stays 1.
- Stall=1 and BranchTaken=1 in the same cycle → IFIDFlush, IDEXFlush and EXMEMFlush all 1, PCWrite=1, FlushCnt=1, StallCnt=0, next state RUN.
- MemBusy=1 for 4 cycles with Stall=1 held → 4 freeze cycles with all enables and flushes 0, WaitCnt=4; the cycle after MemBusy drops, the stall is taken (StallCnt=1).
- Reset asserted while in BUBBLE → next cycle in RUN; a new Stall produces a bubble immediately.
- CNT_W=4 with 20 branch flushes → FlushCnt saturates at 15 and holds.
